alarm_set_controller: RTL and testbench
=======================================

Name: alarm_set_controller

Overview:
- Owns the running current-time register CT and the alarm register ST that feed the display datapath.
- Sequences the user through time-set and alarm-set modes from three button pulses, and drives the display select S and field-blink select CW.
- Raises the alarm output when the enabled alarm time matches the current time.
- Sits between the debounced button front end and the display module.

Parameters:
- DAYS, 7, number of day codes; the day field counts 0..DAYS-1.
- HOURS, 24, number of hour codes; the hour field counts 0..HOURS-1 in binary.

Ports:
- Clk  input  1  system clock
- Clr  input  1  asynchronous active-low reset
- tick_min  input  1  one-cycle pulse, once per minute
- btn_mode  input  1  one-cycle pulse, synchronised and debounced upstream
- btn_next  input  1  one-cycle pulse
- btn_inc  input  1  one-cycle pulse
- CT  output  15  current time: [14:12] day, [11:7] hour (binary), [6:4] minute tens (BCD), [3:0] minute ones (BCD)
- ST  output  16  alarm time: [15] enable, [14:12] always 0, [11:0] same layout as CT
- S  output  2  display select: [1] = show ST, [0] = edit active
- CW  output  2  blinking field: 00 none, 01 minutes, 10 hours, 11 day (TSET) or enable (ASET)
- alarm  output  1  alarm active, level

Behaviour:
- Reset (Clr=0, asynchronous): CT=15'h0000, ST=16'h0000, state RUN/field MIN, S=00, CW=00, alarm=0, silence=0. All outputs are registered.
- Mode FSM, advanced on btn_mode: RUN -> TSET -> ASET -> RUN.
  - Entering TSET selects field DAY.
  - Entering ASET selects field HOUR.
- btn_next cycles the field:
  - TSET: DAY -> HOUR -> MIN -> DAY.
  - ASET: HOUR -> MIN -> EN -> HOUR.
  - Ignored in RUN.
- btn_inc, applied to the selected field only, with no carry into other fields:
  - DAY: +1, DAYS-1 wraps to 0.
  - HOUR: +1, HOURS-1 wraps to 0.
  - MIN: BCD +1, ones 9 -> 0 with tens +1; 59 wraps to 00.
  - EN: toggles ST[15].
- Button priority in the same cycle: mode > next > inc. Lower-priority pulses are dropped.
- Outputs per state:
  - RUN: S=00, CW=00.
  - TSET: S=01, CW per field.
  - ASET: S=11, CW per field.
  - S and CW update in the same cycle as the state change.
- Timekeeping (RUN and ASET only): tick_min advances CT by one minute.
  - 59 -> 00 carries into hour.
  - HOURS-1 -> 0 carries into day.
  - DAYS-1 -> 0 wraps.
  - Example: day 6, 23:59 + tick -> 15'h0000.
- tick_min in TSET is discarded; time freezes while the user edits it.
- tick_min coincident with btn_mode in RUN: the tick is applied and the mode change also occurs.
- Alarm match = ST[15] & (CT[11:0]==ST[11:0]) & state==RUN.
  - alarm = match & ~silence, registered, so it appears 1 cycle after the CT/ST change.
- Silence:
  - Any button pulse while alarm=1 sets silence and is otherwise consumed (no mode change).
  - silence clears when match falls.
- Leaving RUN drops alarm the next cycle.
- Returning to RUN with match true re-raises alarm unless silence is set.
- ST[14:12] is never written and reads 0.

Optional Feature:
- Macro SET_TIMEOUT_EN, default off.
- When defined: a 2-bit counter counts tick_min pulses while in TSET or ASET.
  - Any button pulse clears it.
  - On the 2nd tick with no button, the FSM returns to RUN: S=00, CW=00.
  - The expiring tick is not applied to CT.
  - The counter resets to 0 on Clr and on entry to RUN.
- When not defined: the counter is absent and set modes persist until btn_mode.

Test Plan:
- Assert Clr low mid-operation with CT=15'h1A59 -> same cycle: CT=0, ST=0, S=00, CW=00, alarm=0. Release, then 60 tick_min -> CT=15'h0080 (00 day, hour 1, min 00).
- btn_mode, btn_inc x3, btn_next, btn_inc x25, btn_next, btn_inc x59, btn_inc -> CT=15'h3080 (day 3, hour 1, min 00, no carry). CW sequence 11,10,01; S=01 throughout.
- In TSET, 5 tick_min pulses -> CT unchanged. btn_mode -> S=11, CW=10; btn_mode -> S=00.
- Set ST to hour 0, min 01, enable=1 (ST=16'h8001) with CT=0, return to RUN, then tick -> alarm=1 one cycle after CT=15'h0001. btn_inc -> alarm=0 and CT unchanged. Next tick -> alarm stays 0; silence is cleared.
- btn_mode and btn_inc in the same cycle from RUN -> state TSET, CT day still 0.
- With SET_TIMEOUT_EN, enter ASET and give 2 ticks -> S=00 after the 2nd tick and CT unchanged by that tick. Without the macro -> S stays 11.

Source files
------------

// File: rtl/alarm_set_controller.sv
// alarm_set_controller: owns the current-time (CT) and alarm (ST) registers,
// walks the user through time-set / alarm-set modes from three button pulses,
// drives the display select (S) and blink select (CW), and raises the alarm.
//
// Ports:
//   Clk       system clock
//   Clr       asynchronous active-low reset
//   tick_min  one-cycle pulse per minute
//   btn_mode  mode button pulse  (RUN -> TSET -> ASET -> RUN)
//   btn_next  field-select button pulse
//   btn_inc   increment button pulse
//   CT[14:0]  current time {day[2:0], hour[4:0] binary, min tens[2:0], min ones[3:0]}
//   ST[15:0]  alarm time   {enable, 3'b000, same layout as CT[11:0]}
//   S[1:0]    display select: [1] show ST, [0] edit active
//   CW[1:0]   blinking field: 00 none, 01 min, 10 hour, 11 day/enable
//   alarm     alarm active (level)
//
// Build option: define SET_TIMEOUT_EN to make the set modes fall back to RUN
// after two minute ticks with no button activity.
module alarm_set_controller #(
  parameter int unsigned DAYS  = 7,
  parameter int unsigned HOURS = 24
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic        tick_min,
  input  logic        btn_mode,
  input  logic        btn_next,
  input  logic        btn_inc,
  output logic [14:0] CT,
  output logic [15:0] ST,
  output logic [1:0]  S,
  output logic [1:0]  CW,
  output logic        alarm
);

  localparam int unsigned CT_W = 15;
  localparam int unsigned ST_W = 16;

  typedef enum logic [1:0] {M_RUN = 2'd0, M_TSET = 2'd1, M_ASET = 2'd2} mode_t;
  typedef enum logic [1:0] {F_MIN = 2'd0, F_HOUR = 2'd1, F_DAY = 2'd2, F_EN = 2'd3} field_t;

  mode_t            r_state, w_state;
  field_t           r_field, w_field;
  logic [CT_W-1:0]  r_ct, w_ct;
  logic [ST_W-1:0]  r_st, w_st;
  logic [1:0]       r_s, w_s;
  logic [1:0]       r_cw, w_cw;
  logic             r_alarm, w_alarm;
  logic             r_silence, w_silence;
  logic             w_match;
  logic             w_any_btn;
  logic             w_consume;
  logic             w_tick_ok;
`ifdef SET_TIMEOUT_EN
  logic [1:0]       r_cnt, w_cnt;
`endif

  // BCD minute increment, 59 wraps to 00
  function automatic logic [6:0] min_inc(input logic [6:0] m);
    logic [6:0] r;
    if (m[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      r[6:4] = (m[6:4] == 3'd5) ? 3'd0 : m[6:4] + 3'd1;
    end else begin
      r[3:0] = m[3:0] + 4'd1;
      r[6:4] = m[6:4];
    end
    return r;
  endfunction

  function automatic logic [4:0] hour_inc(input logic [4:0] h);
    return (h == 5'(HOURS - 1)) ? 5'd0 : h + 5'd1;
  endfunction

  function automatic logic [2:0] day_inc(input logic [2:0] d);
    return (d == 3'(DAYS - 1)) ? 3'd0 : d + 3'd1;
  endfunction

  // One-minute advance with carries minute -> hour -> day
  function automatic logic [14:0] ct_tick(input logic [14:0] c);
    logic [14:0] r;
    r      = c;
    r[6:0] = min_inc(c[6:0]);
    if (c[6:0] == 7'h59) begin
      r[11:7] = hour_inc(c[11:7]);
      if (c[11:7] == 5'(HOURS - 1)) r[14:12] = day_inc(c[14:12]);
    end
    return r;
  endfunction

  assign w_match   = r_st[15] && (r_ct[11:0] == r_st[11:0]) && (r_state == M_RUN);
  assign w_any_btn = btn_mode | btn_next | btn_inc;
  // A button press while the alarm sounds only silences it
  assign w_consume = r_alarm & w_any_btn;

  // Next-state, datapath and output decode
  always_comb begin
    w_state   = r_state;
    w_field   = r_field;
    w_ct      = r_ct;
    w_st      = r_st;
    w_silence = r_silence;
    w_tick_ok = tick_min && (r_state != M_TSET);
    w_s       = 2'b00;
    w_cw      = 2'b00;
    w_alarm   = 1'b0;
`ifdef SET_TIMEOUT_EN
    w_cnt     = r_cnt;
`endif

    if (w_consume) begin
      w_silence = 1'b1;
    end else if (btn_mode) begin
      case (r_state)
        M_RUN:   begin w_state = M_TSET; w_field = F_DAY;  end
        M_TSET:  begin w_state = M_ASET; w_field = F_HOUR; end
        default: begin w_state = M_RUN;  w_field = F_MIN;  end
      endcase
    end else if (btn_next) begin
      case (r_state)
        M_TSET: begin
          case (r_field)
            F_DAY:   w_field = F_HOUR;
            F_HOUR:  w_field = F_MIN;
            default: w_field = F_DAY;
          endcase
        end
        M_ASET: begin
          case (r_field)
            F_HOUR:  w_field = F_MIN;
            F_MIN:   w_field = F_EN;
            default: w_field = F_HOUR;
          endcase
        end
        default: ;
      endcase
    end else if (btn_inc) begin
      case (r_state)
        M_TSET: begin
          case (r_field)
            F_DAY:   w_ct[14:12] = day_inc(r_ct[14:12]);
            F_HOUR:  w_ct[11:7]  = hour_inc(r_ct[11:7]);
            F_MIN:   w_ct[6:0]   = min_inc(r_ct[6:0]);
            default: ;
          endcase
        end
        M_ASET: begin
          case (r_field)
            F_HOUR:  w_st[11:7] = hour_inc(r_st[11:7]);
            F_MIN:   w_st[6:0]  = min_inc(r_st[6:0]);
            F_EN:    w_st[15]   = ~r_st[15];
            default: ;
          endcase
        end
        default: ;
      endcase
    end

`ifdef SET_TIMEOUT_EN
    // Inactivity timeout: the second idle tick exits to RUN and is not applied
    if (r_state != M_RUN) begin
      if (w_any_btn) begin
        w_cnt = 2'd0;
      end else if (tick_min) begin
        if (r_cnt == 2'd1) begin
          w_state   = M_RUN;
          w_field   = F_MIN;
          w_tick_ok = 1'b0;
        end else begin
          w_cnt = r_cnt + 2'd1;
        end
      end
    end
    if (w_state == M_RUN) w_cnt = 2'd0;
`endif

    if (w_tick_ok) w_ct = ct_tick(w_ct);

    if (!w_consume && !w_match) w_silence = 1'b0;
    w_alarm    = w_match & ~w_silence;
    w_st[14:12] = 3'b000;

    case (w_state)
      M_TSET:  w_s = 2'b01;
      M_ASET:  w_s = 2'b11;
      default: w_s = 2'b00;
    endcase
    if (w_state != M_RUN) begin
      case (w_field)
        F_MIN:   w_cw = 2'b01;
        F_HOUR:  w_cw = 2'b10;
        default: w_cw = 2'b11;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      r_state   <= M_RUN;
      r_field   <= F_MIN;
      r_ct      <= '0;
      r_st      <= '0;
      r_s       <= 2'b00;
      r_cw      <= 2'b00;
      r_alarm   <= 1'b0;
      r_silence <= 1'b0;
`ifdef SET_TIMEOUT_EN
      r_cnt     <= 2'd0;
`endif
    end else begin
      r_state   <= w_state;
      r_field   <= w_field;
      r_ct      <= w_ct;
      r_st      <= w_st;
      r_s       <= w_s;
      r_cw      <= w_cw;
      r_alarm   <= w_alarm;
      r_silence <= w_silence;
`ifdef SET_TIMEOUT_EN
      r_cnt     <= w_cnt;
`endif
    end
  end

  assign CT    = r_ct;
  assign ST    = r_st;
  assign S     = r_s;
  assign CW    = r_cw;
  assign alarm = r_alarm;

endmodule

// File: tb/tb_alarm_set_controller.sv
// Self-checking bench for alarm_set_controller: a vector table, hand-written
// corner sequences and a randomized run against a minute-count reference model.
module tb_alarm_set_controller;

  logic        Clk;
  logic        Clr;
  logic        tick_min, btn_mode, btn_next, btn_inc;
  logic [14:0] CT;
  logic [15:0] ST;
  logic [1:0]  S, CW;
  logic        alarm;

  int total = 0;
  int bad   = 0;

  alarm_set_controller #(.DAYS(7), .HOURS(24)) dut (
    .Clk(Clk), .Clr(Clr), .tick_min(tick_min), .btn_mode(btn_mode),
    .btn_next(btn_next), .btn_inc(btn_inc), .CT(CT), .ST(ST), .S(S),
    .CW(CW), .alarm(alarm)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: mode 0 RUN, 1 TSET, 2 ASET; field 0 MIN, 1 HOUR, 2 DAY, 3 EN
  int m_day, m_hour, m_minute, m_mode, m_field, m_cnt;
  int a_hour, a_minute;
  bit a_en, m_alarm, m_sil;

  task automatic model_reset();
    m_day = 0; m_hour = 0; m_minute = 0; m_mode = 0; m_field = 0; m_cnt = 0;
    a_hour = 0; a_minute = 0; a_en = 0; m_alarm = 0; m_sil = 0;
  endtask

  task automatic model_update(input logic t, input logic m, input logic n, input logic i);
    bit match, any, consume, tick_ok;
    int tot;
    match   = a_en && (a_hour == m_hour) && (a_minute == m_minute) && (m_mode == 0);
    any     = m | n | i;
    consume = m_alarm && any;
    tick_ok = t && (m_mode != 1);
`ifdef SET_TIMEOUT_EN
    if (m_mode != 0) begin
      if (any) m_cnt = 0;
      else if (t) begin
        m_cnt++;
        if (m_cnt == 2) begin m_mode = 0; m_field = 0; m_cnt = 0; tick_ok = 0; end
      end
    end
`endif
    if (!consume) begin
      if (m) begin
        m_mode  = (m_mode + 1) % 3;
        m_field = (m_mode == 1) ? 2 : (m_mode == 2) ? 1 : 0;
        m_cnt   = 0;
      end else if (n) begin
        if (m_mode == 1) m_field = (m_field == 2) ? 1 : (m_field == 1) ? 0 : 2;
        else if (m_mode == 2) m_field = (m_field == 1) ? 0 : (m_field == 0) ? 3 : 1;
      end else if (i) begin
        if (m_mode == 1) begin
          if (m_field == 2) m_day = (m_day + 1) % 7;
          else if (m_field == 1) m_hour = (m_hour + 1) % 24;
          else m_minute = (m_minute + 1) % 60;
        end else if (m_mode == 2) begin
          if (m_field == 1) a_hour = (a_hour + 1) % 24;
          else if (m_field == 0) a_minute = (a_minute + 1) % 60;
          else a_en = !a_en;
        end
      end
    end
    if (tick_ok) begin
      tot      = ((m_day * 24 + m_hour) * 60 + m_minute + 1) % (7 * 24 * 60);
      m_day    = tot / 1440;
      m_hour   = (tot / 60) % 24;
      m_minute = tot % 60;
    end
    if (consume) m_sil = 1;
    else if (!match) m_sil = 0;
    m_alarm = match && !m_sil;
  endtask

  function automatic logic [14:0] exp_ct();
    return {3'(m_day), 5'(m_hour), 3'(m_minute / 10), 4'(m_minute % 10)};
  endfunction
  function automatic logic [15:0] exp_st();
    return {a_en, 3'b000, 5'(a_hour), 3'(a_minute / 10), 4'(a_minute % 10)};
  endfunction
  function automatic logic [1:0] exp_s();
    return (m_mode == 1) ? 2'b01 : (m_mode == 2) ? 2'b11 : 2'b00;
  endfunction
  function automatic logic [1:0] exp_cw();
    if (m_mode == 0) return 2'b00;
    return (m_field == 0) ? 2'b01 : (m_field == 1) ? 2'b10 : 2'b11;
  endfunction

  task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic check_model(input string nm);
    cmp({nm, " CT"}, {1'b0, CT}, {1'b0, exp_ct()});
    cmp({nm, " ST"}, ST, exp_st());
    cmp({nm, " S"}, {14'd0, S}, {14'd0, exp_s()});
    cmp({nm, " CW"}, {14'd0, CW}, {14'd0, exp_cw()});
    cmp({nm, " alarm"}, {15'd0, alarm}, {15'd0, m_alarm});
  endtask

  // Drive one cycle of inputs; the model follows the same edge
  task automatic step(input logic t, input logic m, input logic n, input logic i);
    tick_min = t; btn_mode = m; btn_next = n; btn_inc = i;
    @(posedge Clk);
    model_update(t, m, n, i);
    #1;
    tick_min = 0; btn_mode = 0; btn_next = 0; btn_inc = 0;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Clr = 1'b0;
    #2;
    Clr = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic        t, m, n, i;
    logic [14:0] ct;
    logic [15:0] st;
    logic [1:0]  s, cw;
    logic        al;
  } vec_t;

  vec_t vt[16];

  initial begin
    vt[0]  = '{0, 1, 0, 0, 15'h0000, 16'h0000, 2'b01, 2'b11, 0}; // enter TSET, DAY
    vt[1]  = '{0, 0, 0, 1, 15'h1000, 16'h0000, 2'b01, 2'b11, 0};
    vt[2]  = '{0, 0, 0, 1, 15'h2000, 16'h0000, 2'b01, 2'b11, 0};
    vt[3]  = '{0, 0, 0, 1, 15'h3000, 16'h0000, 2'b01, 2'b11, 0};
    vt[4]  = '{0, 0, 1, 0, 15'h3000, 16'h0000, 2'b01, 2'b10, 0}; // HOUR
    vt[5]  = '{1, 0, 0, 0, 15'h3000, 16'h0000, 2'b01, 2'b10, 0}; // tick frozen
    vt[6]  = '{0, 1, 0, 1, 15'h3000, 16'h0000, 2'b11, 2'b10, 0}; // mode wins, inc dropped
    vt[7]  = '{0, 0, 0, 1, 15'h3000, 16'h0080, 2'b11, 2'b10, 0};
    vt[8]  = '{0, 0, 1, 0, 15'h3000, 16'h0080, 2'b11, 2'b01, 0};
    vt[9]  = '{0, 0, 1, 0, 15'h3000, 16'h0080, 2'b11, 2'b11, 0}; // EN
    vt[10] = '{0, 0, 0, 1, 15'h3000, 16'h8080, 2'b11, 2'b11, 0};
    vt[11] = '{1, 0, 0, 0, 15'h3001, 16'h8080, 2'b11, 2'b11, 0}; // ASET keeps time
    vt[12] = '{0, 1, 0, 0, 15'h3001, 16'h8080, 2'b00, 2'b00, 0};
    vt[13] = '{0, 0, 1, 0, 15'h3001, 16'h8080, 2'b00, 2'b00, 0}; // next ignored in RUN
    vt[14] = '{0, 0, 0, 1, 15'h3001, 16'h8080, 2'b00, 2'b00, 0}; // inc ignored in RUN
    vt[15] = '{1, 0, 0, 0, 15'h3002, 16'h8080, 2'b00, 2'b00, 0};
  end

  initial begin
    string nm;
    Clr = 1'b0; tick_min = 0; btn_mode = 0; btn_next = 0; btn_inc = 0;
    model_reset();
    #12;
    Clr = 1'b1;
    #1;
    cmp("reset CT", {1'b0, CT}, 16'h0000);
    cmp("reset ST", ST, 16'h0000);
    cmp("reset S/CW", {12'd0, S, CW}, 16'h0000);
    cmp("reset alarm", {15'd0, alarm}, 16'h0000);

    // Vector table
    for (int k = 0; k < 16; k++) begin
      step(vt[k].t, vt[k].m, vt[k].n, vt[k].i);
      nm = $sformatf("vec%0d", k);
      cmp({nm, " CT"}, {1'b0, CT}, {1'b0, vt[k].ct});
      cmp({nm, " ST"}, ST, vt[k].st);
      cmp({nm, " S/CW"}, {12'd0, S, CW}, {12'd0, vt[k].s, vt[k].cw});
      cmp({nm, " alarm"}, {15'd0, alarm}, {15'd0, vt[k].al});
    end

    // Reach CT=1A59, then async clear mid-cycle
    do_reset();
    step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    for (int k = 0; k < 20; k++) step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    for (int k = 0; k < 59; k++) step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    cmp("preclr CT", {1'b0, CT}, 16'h1A59);
    #2;
    Clr = 1'b0;
    #1;
    cmp("async clr CT", {1'b0, CT}, 16'h0000);
    cmp("async clr ST", ST, 16'h0000);
    cmp("async clr S/CW", {12'd0, S, CW}, 16'h0000);
    cmp("async clr alarm", {15'd0, alarm}, 16'h0000);
    #2;
    Clr = 1'b1;
    model_reset();
    for (int k = 0; k < 60; k++) step(1, 0, 0, 0);
    cmp("60 ticks CT", {1'b0, CT}, 16'h0080);

    // Field editing without carry
    do_reset();
    step(0, 1, 0, 0);
    cmp("tset S/CW day", {12'd0, S, CW}, 16'h0007);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    cmp("tset S/CW hour", {12'd0, S, CW}, 16'h0006);
    for (int k = 0; k < 25; k++) step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    cmp("tset S/CW min", {12'd0, S, CW}, 16'h0005);
    for (int k = 0; k < 60; k++) step(0, 0, 0, 1);
    cmp("edit CT", {1'b0, CT}, 16'h3080);

    // Ticks while in TSET (timeout build leaves on the 2nd tick)
    for (int k = 0; k < 5; k++) step(1, 0, 0, 0);
`ifdef SET_TIMEOUT_EN
    cmp("tset ticks CT", {1'b0, CT}, 16'h3083);
    cmp("tset ticks S", {14'd0, S}, 16'h0000);
`else
    cmp("tset ticks CT", {1'b0, CT}, 16'h3080);
    cmp("tset ticks S", {14'd0, S}, 16'h0001);
    step(0, 1, 0, 0);
    cmp("aset S/CW", {12'd0, S, CW}, 16'h000E);
    step(0, 1, 0, 0);
    cmp("back run S", {14'd0, S}, 16'h0000);
`endif
    check_model("after tset");

    // Alarm raise, silence and silence release
    do_reset();
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    cmp("alarm ST", ST, 16'h8001);
    step(1, 0, 0, 0);
    cmp("alarm tick CT", {1'b0, CT}, 16'h0001);
    cmp("alarm not yet", {15'd0, alarm}, 16'h0000);
    step(0, 0, 0, 0);
    cmp("alarm raised", {15'd0, alarm}, 16'h0001);
    step(0, 0, 0, 1);
    cmp("silenced alarm", {15'd0, alarm}, 16'h0000);
    cmp("silenced CT", {1'b0, CT}, 16'h0001);
    cmp("silenced S", {14'd0, S}, 16'h0000);
    step(0, 0, 0, 0);
    cmp("silence holds", {15'd0, alarm}, 16'h0000);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    cmp("after match alarm", {15'd0, alarm}, 16'h0000);
    check_model("after alarm");

    // Mode and inc together from RUN
    step(0, 1, 0, 1);
    cmp("mode+inc S/CW", {12'd0, S, CW}, 16'h0007);
    cmp("mode+inc day", {13'd0, CT[14:12]}, 16'h0000);

    // Set-mode timeout from ASET
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    cmp("aset tick1 CT", {1'b0, CT}, 16'h0003);
    step(1, 0, 0, 0);
`ifdef SET_TIMEOUT_EN
    cmp("timeout S", {14'd0, S}, 16'h0000);
    cmp("timeout CT", {1'b0, CT}, 16'h0003);
`else
    cmp("no timeout S", {14'd0, S}, 16'h0003);
    cmp("no timeout CT", {1'b0, CT}, 16'h0004);
`endif
    check_model("after timeout");

    // Randomized run against the model
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      step(($urandom_range(3) == 0), ($urandom_range(11) == 0),
           ($urandom_range(4) == 0), ($urandom_range(2) == 0));
      check_model($sformatf("rand%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard bound on run time
  initial begin
    #2000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "bench time limit");
  end

endmodule
